reg_wb_queue: RTL and testbench
===============================

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries, power of two >= 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports listed below.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  writeback request valid.
REQ-008 SHALL have port in_ready  output  1  queue can accept a request.
REQ-009 SHALL have port in_addr  input  ADDR_WIDTH  destination register.
REQ-010 SHALL have port in_data  input  DATA_WIDTH  writeback value.
REQ-011 SHALL have port hold  input  1  pause draining to the register file.
REQ-012 SHALL have port flush  input  1  discard all queued entries.
REQ-013 SHALL have port rf_wen  output  1  register file write enable.
REQ-014 SHALL have port rf_waddr  output  ADDR_WIDTH  register file write address.
REQ-015 SHALL have port rf_wdata  output  DATA_WIDTH  register file write data.
REQ-016 SHALL have ports byp_raddr1, byp_raddr2  input  ADDR_WIDTH  bypass lookup addresses.
REQ-017 SHALL have ports byp_hit1, byp_hit2  output  1  pending write found for lookup.
REQ-018 SHALL have ports byp_data1, byp_data2  output  DATA_WIDTH  youngest pending value.
REQ-019 SHALL have port count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-020 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-021 SHALL drive in_ready = !full && !flush, combinationally.
REQ-022 SHALL accept but not enqueue requests with in_addr == 0; count unchanged.
REQ-023 SHALL store entries in FIFO order; head pointer and tail pointer wrap modulo DEPTH.
REQ-024 SHALL drive rf_wen = !empty && !hold && !flush, combinationally; rf_waddr/rf_wdata = head entry, all zero when empty.
REQ-025 SHALL pop the head on every edge where rf_wen is 1 (register file always accepts).
REQ-026 SHALL make an accepted entry visible on rf_wen no earlier than the cycle after acceptance (no input-to-output pass-through).
REQ-027 SHALL permit push and pop in the same cycle when not full; count unchanged.
REQ-028 SHALL, on a flush edge, empty the queue; any same-cycle push is dropped (in_ready already 0) and no write is issued.
REQ-029 SHALL, when full, hold in_ready low until a pop completes, even if hold is high indefinitely.
REQ-030 SHALL assert byp_hitN when any valid entry matches byp_raddrN and byp_raddrN != 0; byp_dataN = youngest matching entry, else zero.
REQ-031 SHALL compute bypass outputs combinationally from current queue contents only (not from in_* of the same cycle).
REQ-032 SHALL keep count equal to occupied entries, range 0..DEPTH, never wrapping.

Reset
REQ-033 SHALL, while rst_n is low, clear head, tail and count to 0, independent of clk.
REQ-034 SHALL hold in reset: rf_wen=0, rf_waddr=0, rf_wdata=0, byp_hit1/2=0, byp_data1/2=0, in_ready=1.
REQ-035 SHALL discard in-flight entries on reset mid-operation; first post-reset accept lands in entry 0.

Configuration
REQ-036 SHALL, with macro REG_WB_QUEUE_BYPASS_EN defined, implement REQ-030/031 as specified.
REQ-037 SHALL, without REG_WB_QUEUE_BYPASS_EN, tie byp_hit1/2 and byp_data1/2 to 0 and omit comparator logic; queue behaviour unchanged.

Verification
REQ-038 SHALL check: push (3,0xA5A5A5A5) with hold=0 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0xA5A5A5A5; following cycle rf_wen=0, count=0.
REQ-039 SHALL check: hold=1, push 4 entries (addr 1..4) -> count=4, in_ready=0, rf_wen=0; release hold -> writes 1,2,3,4 on four consecutive cycles.
REQ-040 SHALL check: push (0,0xFFFFFFFF) -> in_ready stays 1, count=0, rf_wen never asserted.
REQ-041 SHALL check (BYPASS_EN): hold=1, push (7,0x11) then (7,0x22), byp_raddr1=7 -> byp_hit1=1, byp_data1=0x22; byp_raddr2=0 -> byp_hit2=0.
REQ-042 SHALL check: count=3 under hold, assert flush with in_valid=1 -> next cycle count=0, rf_wen=0, no write issued.
REQ-043 SHALL check: drop rst_n asynchronously mid-drain at count=2 -> rf_wen=0 immediately, count=0, in_ready=1.

Source files
------------

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: small FIFO of pending register-file writebacks.
// Requests enter on in_valid && in_ready, drain to the register file one per
// cycle unless held or flushed, and can be looked up by two bypass ports.
// Optional feature: define REG_WB_QUEUE_BYPASS_EN to build the bypass
// comparators; otherwise the bypass outputs are tied to zero.
module reg_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  input  logic [ADDR_WIDTH-1:0]    byp_raddr1,
  input  logic [ADDR_WIDTH-1:0]    byp_raddr2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [DATA_WIDTH-1:0]    byp_data1,
  output logic [DATA_WIDTH-1:0]    byp_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];

  logic empty;
  logic full;
  logic push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = !full && !flush;
  // Writes to r0 are accepted (handshake completes) but never stored.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign rf_wen   = !empty && !hold && !flush;
  assign rf_waddr = empty ? '0 : addr_mem_q[head_q];
  assign rf_wdata = empty ? '0 : data_mem_q[head_q];
  assign count    = count_q;

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)   tail_d = tail_q + PTR_W'(1);
      if (rf_wen) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(rf_wen);
    end
  end

  // Next-state for entry storage: only the tail slot is written on a push.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[tail_q] = in_addr;
      data_mem_d[tail_q] = in_data;
    end
  end

  // Control state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload; validity comes from head/count, so no reset is needed.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef REG_WB_QUEUE_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Scan oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    byp_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      byp_idx = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        if ((byp_raddr1 != '0) && (addr_mem_q[byp_idx] == byp_raddr1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = data_mem_q[byp_idx];
        end
        if ((byp_raddr2 != '0) && (addr_mem_q[byp_idx] == byp_raddr2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = data_mem_q[byp_idx];
        end
      end
    end
  end
`else
  logic unused_byp_raddr;

  assign unused_byp_raddr = ^{byp_raddr1, byp_raddr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: directed stimulus for reg_wb_queue. Expected register-file
// writes are queued when a request is issued; a negedge monitor pops and
// compares them whenever rf_wen is presented.
module tb_reg_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  byp_raddr1;
  logic [4:0]  byp_raddr2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic [2:0]  count;

`ifdef REG_WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  total = 0;
  int  bad   = 0;

  reg_wb_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .flush(flush),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rf_wen"},   rf_wen,   0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_count"},    count,    0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_hit1"},     byp_hit1, 0);
    chk({tag, "_hit2"},     byp_hit2, 0);
    chk({tag, "_data1"},    byp_data1, 0);
    chk({tag, "_data2"},    byp_data2, 0);
  endtask

  // Scoreboard monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rf_wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== {mon_e.a, mon_e.d}) begin
          bad++;
          $display("FAIL wb_data: got addr=%0d data=%h expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    hold = 1'b0; flush = 1'b0; byp_raddr1 = 5'd3; byp_raddr2 = 5'd3;

    // Reset state
    at_neg();
    chk_idle("reset");
    tick();
    rst_n = 1'b1;

    // Single write drains the cycle after acceptance
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hA5A5A5A5;
    exp_q.push_back('{5'd3, 32'hA5A5A5A5});
    at_neg();
    chk("t1_no_passthru", rf_wen, 0);
    chk("t1_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t1_wen", rf_wen, 1);
    chk("t1_count1", count, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 32'hA5A5A5A5);
    tick();
    at_neg();
    chk("t1_wen_off", rf_wen, 0);
    chk("t1_count0", count, 0);

    // Fill under hold, stay full, then drain in order
    tick();
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h1000_0000 + 32'(i);
      exp_q.push_back('{5'(i), 32'h1000_0000 + 32'(i)});
      tick();
    end
    in_addr = 5'd9; in_data = 32'hDEAD_0009;
    at_neg();
    chk("t2_count4", count, 4);
    chk("t2_ready0", in_ready, 0);
    chk("t2_wen0", rf_wen, 0);
    tick();
    tick();
    at_neg();
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", in_ready, 0);
    tick();
    in_valid = 1'b0; hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      at_neg();
      chk($sformatf("t2_drain%0d_wen", i), rf_wen, 1);
      chk($sformatf("t2_drain%0d_addr", i), rf_waddr, i);
      tick();
    end
    at_neg();
    chk("t2_end_count", count, 0);
    chk("t2_end_wen", rf_wen, 0);

    // r0 writes are accepted but dropped
    tick();
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
    at_neg();
    chk("t3_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t3_count", count, 0);
    chk("t3_wen", rf_wen, 0);
    tick();
    at_neg();
    chk("t3_wen2", rf_wen, 0);

    // Bypass returns the youngest match and ignores same-cycle input
    tick();
    hold = 1'b1; byp_raddr1 = 5'd7; byp_raddr2 = 5'd0;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
    exp_q.push_back('{5'd7, 32'h11});
    at_neg();
    chk("t4_no_comb_hit", byp_hit1, 0);
    tick();
    in_data = 32'h22;
    exp_q.push_back('{5'd7, 32'h22});
    at_neg();
    chk("t4_hit1_first", byp_hit1, BYP);
    chk("t4_data1_first", byp_data1, BYP ? 32'h11 : 32'h0);
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t4_hit1", byp_hit1, BYP);
    chk("t4_data1", byp_data1, BYP ? 32'h22 : 32'h0);
    chk("t4_hit2_r0", byp_hit2, 0);
    chk("t4_data2_r0", byp_data2, 0);
    byp_raddr2 = 5'd7;
    #1;
    chk("t4_hit2", byp_hit2, BYP);
    chk("t4_data2", byp_data2, BYP ? 32'h22 : 32'h0);
    byp_raddr2 = 5'd5;
    #1;
    chk("t4_hit2_miss", byp_hit2, 0);
    tick();
    hold = 1'b0;
    tick();
    tick();
    at_neg();
    chk("t4_drained_count", count, 0);
    chk("t4_drained_hit1", byp_hit1, 0);

    // Flush with a simultaneous push discards everything
    tick();
    hold = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    at_neg();
    chk("t5_count3", count, 3);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_addr = 5'd13; in_data = 32'h13;
    at_neg();
    chk("t5_ready0", in_ready, 0);
    chk("t5_wen0", rf_wen, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; hold = 1'b0;
    at_neg();
    chk("t5_count0", count, 0);
    chk("t5_wen_after", rf_wen, 0);
    tick();
    at_neg();
    chk("t5_wen_later", rf_wen, 0);

    // Asynchronous reset mid-drain
    tick();
    hold = 1'b1;
    for (int i = 20; i <= 21; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h100 + 32'(i);
      exp_q.push_back('{5'(i), 32'h100 + 32'(i)});
      tick();
    end
    in_valid = 1'b0; hold = 1'b0;
    at_neg();
    chk("t6_count2", count, 2);
    chk("t6_wen1", rf_wen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_async_wen", rf_wen, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_ready", in_ready, 1);
    byp_raddr1 = 5'd20; byp_raddr2 = 5'd21;
    tick();
    at_neg();
    chk_idle("t6_in_reset");
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h55;
    exp_q.push_back('{5'd5, 32'h55});
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t6_post_wen", rf_wen, 1);
    chk("t6_post_addr", rf_waddr, 5);
    tick();
    at_neg();
    chk("t6_post_count", count, 0);

    repeat (3) tick();
    chk("sb_leftover", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
